// File: rtl/stc_pkg.sv
// stc_pkg: shared types and sizing helpers for the bit-serial negator
package stc_pkg;
  typedef enum logic {PASS = 1'b0, INV = 1'b1} stc_state_e;
  localparam int STC_MIN_CW = 1;
  function automatic int stc_cnt_w(input int w);
    return ($clog2(w) > STC_MIN_CW) ? $clog2(w) : STC_MIN_CW;
  endfunction
endpackage

// File: rtl/serial_twos_comp_if.sv
// serial_twos_comp_if: serial data, mode and result bundle for the negator lanes
interface serial_twos_comp_if #(parameter int CHANNELS = 4);
  logic                in_valid;
  logic [CHANNELS-1:0] in_bit;
  logic [CHANNELS-1:0] neg_en;
  logic                out_valid;
  logic [CHANNELS-1:0] out_bit;
  logic                out_first;
  logic                out_last;
  logic [CHANNELS-1:0] ovf;
  modport master (output in_valid, in_bit, neg_en, input out_valid, out_bit, out_first, out_last, ovf);
  modport slave (input in_valid, in_bit, neg_en, output out_valid, out_bit, out_first, out_last, ovf);
endinterface

// File: rtl/stc_lane.sv
// stc_lane: one serial lane, tracks first input 1 and inverts the bits that follow it
module stc_lane
  import stc_pkg::*;
(
  input  logic t_clk,
  input  logic r_n,
  input  logic clr,
  input  logic accept,
  input  logic first,
  input  logic last,
  input  logic in_bit,
  input  logic neg_en,
  output logic out_bit,
  output logic ovf
);
  stc_state_e state;
  logic mode_q;
  logic mode;
  assign mode = first ? neg_en : mode_q;
  // lane FSM, mode capture and registered result/overflow
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state   <= PASS;
      mode_q  <= 1'b0;
      out_bit <= 1'b0;
      ovf     <= 1'b0;
    end else if (clr) begin
      state <= PASS;
      ovf   <= 1'b0;
    end else if (accept) begin
      mode_q  <= mode;
      out_bit <= (mode && state == INV) ? ~in_bit : in_bit;
      ovf     <= last & mode & (state == PASS) & in_bit;
      state   <= last ? PASS : (in_bit ? INV : state);
    end else begin
      ovf <= 1'b0;
    end
  end
endmodule

// File: rtl/serial_twos_comp.sv
// serial_twos_comp: multi-lane bit-serial two's-complement negator with word framing
module serial_twos_comp
  import stc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input logic                t_clk,
  input logic                r_n,
  input logic                clr,
  serial_twos_comp_if.slave  bus
);
  localparam int CW = stc_cnt_w(WIDTH);
  logic [CW-1:0] bcnt;
  logic accept, first, last;
  logic [CHANNELS-1:0] ob, ov;
  assign accept = bus.in_valid & ~clr;
  assign first  = (bcnt == '0);
  assign last   = (bcnt == CW'(WIDTH - 1));
  assign bus.out_bit = ob;
  assign bus.ovf     = ov;
  // shared bit position within the word; clr wins over an accepted slot
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) bcnt <= '0;
    else if (clr) bcnt <= '0;
    else if (bus.in_valid) bcnt <= last ? '0 : bcnt + CW'(1);
  end
  // framing strobes follow the accepted slot by one cycle
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= accept;
      bus.out_first <= accept & first;
      bus.out_last  <= accept & last;
    end
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    stc_lane u_lane (
      .t_clk   (t_clk),
      .r_n     (r_n),
      .clr     (clr),
      .accept  (accept),
      .first   (first),
      .last    (last),
      .in_bit  (bus.in_bit[k]),
      .neg_en  (bus.neg_en[k]),
      .out_bit (ob[k]),
      .ovf     (ov[k])
    );
  end
endmodule

// File: tb/tb_serial_twos_comp.sv
// tb_serial_twos_comp: directed vectors for the 4-lane, 8-bit serial negator
module tb_serial_twos_comp;
  logic t_clk = 1'b0;
  logic r_n;
  logic clr;
  int vectors = 0;
  int miss = 0;
  serial_twos_comp_if #(.CHANNELS(4)) bus ();
  serial_twos_comp #(.WIDTH(8), .CHANNELS(4)) dut (
    .t_clk (t_clk),
    .r_n   (r_n),
    .clr   (clr),
    .bus   (bus)
  );
  always #5 t_clk = ~t_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_word(input logic [31:0] w, input logic [3:0] n0, input logic [3:0] n1,
                           input logic [31:0] exp, input logic [3:0] exp_ovf, input int stall_at);
    logic [31:0] got;
    logic [3:0] held;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) bus.in_bit[k] = w[8*k+i];
      bus.neg_en   = (i < 4) ? n0 : n1;
      bus.in_valid = 1'b1;
      @(posedge t_clk); #1;
      for (int k = 0; k < 4; k++) got[8*k+i] = bus.out_bit[k];
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_first", 32'(bus.out_first), 32'(i == 0));
      chk("out_last", 32'(bus.out_last), 32'(i == 7));
      chk("ovf", 32'(bus.ovf), (i == 7) ? 32'(exp_ovf) : 32'd0);
      if (i == stall_at) begin
        for (int k = 0; k < 4; k++) held[k] = exp[8*k+i];
        bus.in_valid = 1'b0;
        repeat (3) begin
          bus.in_bit = ~bus.in_bit;
          bus.neg_en = ~bus.neg_en;
          @(posedge t_clk); #1;
          chk("stall_valid", 32'(bus.out_valid), 32'd0);
          chk("stall_first_last", {30'd0, bus.out_first, bus.out_last}, 32'd0);
          chk("stall_ovf", 32'(bus.ovf), 32'd0);
          chk("stall_hold", 32'(bus.out_bit), 32'(held));
        end
      end
    end
    chk("word", got, exp);
  endtask
  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_bit   = 4'hF;
      bus.neg_en   = 4'hF;
      bus.in_valid = 1'b1;
      @(posedge t_clk); #1;
    end
  endtask
  initial begin
    r_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = '0;
    bus.neg_en   = '0;
    repeat (2) @(posedge t_clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bit", 32'(bus.out_bit), 32'd0);
    chk("rst_first_last", {30'd0, bus.out_first, bus.out_last}, 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    r_n = 1'b1;
    @(posedge t_clk); #1;
    send_word(32'h35008006, 4'b0111, 4'b0111, 32'h350080FA, 4'b0010, -1);
    send_word(32'h35FF7F01, 4'b0111, 4'b1000, 32'h350181FF, 4'b0000, -1);
    send_word(32'h55808001, 4'b1101, 4'b1101, 32'hAB8080FF, 4'b0100, 2);
    partial(6);
    bus.in_valid = 1'b0;
    r_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_bit", 32'(bus.out_bit), 32'd0);
    chk("arst_first_last", {30'd0, bus.out_first, bus.out_last}, 32'd0);
    chk("arst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge t_clk); #1;
    r_n = 1'b1;
    @(posedge t_clk); #1;
    send_word(32'h00100302, 4'hF, 4'hF, 32'h00F0FDFE, 4'b0000, -1);
    partial(4);
    clr = 1'b1;
    bus.in_bit = 4'hF;
    bus.in_valid = 1'b1;
    @(posedge t_clk); #1;
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_first_last", {30'd0, bus.out_first, bus.out_last}, 32'd0);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    clr = 1'b0;
    send_word(32'h0080017F, 4'hF, 4'hF, 32'h0080FF81, 4'b0100, -1);
    bus.in_valid = 1'b0;
    @(posedge t_clk); #1;
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/serial_twos_comp.md
# serial_twos_comp

Parametrised bit-serial two's-complement negator, the multi-lane successor to the single-bit `invert` cell. It accepts CHANNELS parallel LSB-first serial streams framed into WIDTH-bit words, and negates or passes each word per lane. It tracks word boundaries internally, supports stalling, and flags the one unrepresentable negation. It sits between serialisers and any downstream bit-serial adder or accumulator.

## Interface
Parameters:
- WIDTH, 8: bits per word; legal range 2..64.
- CHANNELS, 4: number of independent serial lanes; legal range 1..32.

Ports:
- t_clk  input  1  single clock; all state updates on the rising edge.
- r_n  input  1  reset; asynchronous assert, active-low.
- clr  input  1  synchronous framing clear; returns to word start with no reset of outputs beyond those listed in Operation.
- in_valid  input  1  input bit slot valid, shared by all lanes.
- in_bit  input  CHANNELS  current serial bit per lane, LSB first.
- neg_en  input  CHANNELS  per-lane mode, sampled only on the first bit of a word: 1 = negate, 0 = pass.
- out_valid  output  1  registered copy of accepted in_valid.
- out_bit  output  CHANNELS  result bit per lane.
- out_first  output  1  out_bit holds bit 0 of a word.
- out_last  output  1  out_bit holds bit WIDTH-1 of a word.
- ovf  output  CHANNELS  negation overflow; meaningful only when out_valid and out_last are both 1, otherwise 0.

## Operation
- The shared bit counter `bcnt` is $clog2(WIDTH) bits wide. It advances only on accepted slots (in_valid=1). It wraps from WIDTH-1 to 0.
- Each lane runs a 2-state FSM:
  - PASS: no 1 seen yet in the current word.
  - INV: a 1 has been seen earlier in the current word.
- Each lane holds a mode register `mode_q`, loaded from neg_en[k] when an accepted slot has bcnt==0. For the first bit of a word, the freshly sampled neg_en value is used directly.
- Output bit on an accepted slot:
  - Negate mode: out = in_bit in PASS; out = ~in_bit in INV.
  - Pass mode: out = in_bit.
- Transitions on an accepted slot:
  - PASS→INV when in_bit=1 and the slot is not the last bit of the word.
  - Any state→PASS on the last bit of the word (bcnt==WIDTH-1).
  - The FSM tracks input ones regardless of mode.
- ovf[k]=1 on the last bit when mode is negate, the state is PASS, and in_bit=1. This is exactly the input 1000…0, i.e. -2^(WIDTH-1). That word's output equals its input.
- A zero word negates to zero with ovf=0.
- Stall: with in_valid=0, bcnt, FSMs and mode_q hold. The outputs out_valid, out_first, out_last and ovf drop to 0. out_bit holds its last value.
- clr=1 (with r_n high):
  - next edge sets bcnt=0, all lanes to PASS, out_valid=0, out_first=0, out_last=0, ovf=0;
  - any in_valid on that cycle is discarded;
  - clr has priority over in_valid.

## Timing
- Latency: one cycle. The bit accepted at edge n appears on out_* after edge n, together with out_valid.
- Throughput: one bit per lane per cycle. One word completes every WIDTH accepted slots.
- Reset (r_n=0), asynchronous:
  - bcnt=0, all lanes PASS, mode_q=0;
  - out_valid=0, out_bit=0, out_first=0, out_last=0, ovf=0.
- Reset asserted mid-word abandons the word. The first accepted slot after release is bit 0.
- No back-pressure: the downstream block must accept every out_valid cycle.
- A neg_en change in the middle of a word has no effect until the next bit 0.

## Structure
- Package `stc_pkg`:
  - lane state enum `stc_state_e` {PASS, INV};
  - `localparam` helper for counter width, computed as $clog2(WIDTH) with a minimum of 1.
- Sub-module `stc_lane`, one instance per channel via generate. It holds the FSM, mode_q and the output/ovf logic. Its inputs are the shared accept, first and last strobes from the top-level counter.
- The top level holds bcnt, the clr/in_valid priority logic, and the out_valid/out_first/out_last registers.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.
- Negate: lane 0 gets 0x06 (serial 0,1,1,0,0,0,0,0) with neg_en=1 → output 0xFA (0,1,0,1,1,1,1,1); ovf=0; out_first on bit 0, out_last on bit 7.
- Overflow and zero: lane 1 gets 0x80 and lane 2 gets 0x00, both negate → outputs 0x80 with ovf[1]=1, and 0x00 with ovf[2]=0.
- Mixed modes: lane 3 gets 0x35 with neg_en=0 → 0x35. The same word with neg_en toggled at bit 4 → still 0x35, and ovf stays 0.
- Stall: 0x01 with negate, with in_valid low for 3 cycles after bit 2 → output 0xFF. out_valid drops for exactly the 3 stall cycles, and the word completes after 8 accepted slots.
- Reset mid-word: r_n pulsed low after bit 5 → all outputs 0 immediately. The next word 0x02 with negate → 0xFE, starting with out_first.
- clr mid-word: clr after bit 3, with in_valid=1 on the same cycle → that bit is dropped. The next accepted bit is treated as bit 0, and 0x7F with negate → 0x81.
